// File: rtl/life_pkg.sv
// Shared types and sizing helpers for the life grid sequencer.
package life_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      HALT = 2'd3
   } seq_state_t;

   // Counter width for n distinct values. Always at least one bit, so that
   // single-row grids and one-cycle step periods still give a legal vector.
   function automatic int width_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/life_grid_sequencer_step_timer.sv
// Generation cadence timer: emits one tick every STEP_PERIOD enabled cycles.
// Implemented as a down-counter of cycles remaining until the next tick.
module step_timer
   import life_pkg::*;
#(
   parameter int STEP_PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int CW = width_min1(STEP_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(STEP_PERIOD - 1);

   logic [CW-1:0] remaining;

   assign tick = enable && !clear && (remaining == '0);

   // Reload on clear or terminal count, otherwise count down while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= LAST;
      end else if (clear) begin
         remaining <= LAST;
      end else if (enable) begin
         if (remaining == '0) remaining <= LAST;
         else                 remaining <= remaining - CW'(1);
      end
   end

endmodule

// File: rtl/life_grid_sequencer.sv
// Holds the registered life grid, loads it row by row, and sequences
// generation updates (single step or free run) from an external
// combinational next-state stage.
//
//   state | meaning
//   IDLE  | grid held; step runs one generation, run enters RUN
//   LOAD  | accepting rows 0..GRID_HEIGHT-1 on row_valid
//   RUN   | one generation every STEP_PERIOD cycles while run is high
//   HALT  | grid stable or extinct in RUN; frozen until load_start
module life_grid_sequencer
   import life_pkg::*;
#(
   parameter int GRID_WIDTH     = 8,
   parameter int GRID_HEIGHT    = 8,
   parameter int STEP_PERIOD    = 4,
   parameter int GEN_WIDTH      = 16,
   parameter int HALT_ON_STABLE = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              load_start,
   input  logic [GRID_WIDTH-1:0]             row_data,
   input  logic                              row_valid,
   output logic                              row_ready,
   input  logic                              run,
   input  logic                              step,
   input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] next_state,
   output logic [GRID_WIDTH*GRID_HEIGHT-1:0] grid_state,
   output logic [GEN_WIDTH-1:0]              generation,
   output logic                              stable,
   output logic                              extinct,
   output logic [1:0]                        seq_state
);

   localparam int RW = width_min1(GRID_HEIGHT);
   localparam logic [RW-1:0] LAST_ROW = RW'(GRID_HEIGHT - 1);

   seq_state_t    state;
   logic [RW-1:0] row_idx;
   logic          tick;
   logic          do_update;
   logic          stable_next;
   logic          extinct_next;

   assign row_ready = (state == LOAD);
   assign seq_state = state;

   assign stable_next  = (next_state == grid_state);
   assign extinct_next = (next_state == '0);

   // load_start overrides any pending generation in the same cycle.
   assign do_update = !load_start &&
                      (((state == IDLE) && step) ||
                       ((state == RUN) && run && tick));

   step_timer #(.STEP_PERIOD(STEP_PERIOD)) u_step_timer (
      .clk    (clk),
      .rst    (rst),
      .enable (state == RUN),
      .clear  ((state != RUN) || !run || load_start),
      .tick   (tick)
   );

   // Sequencer FSM, grid register, generation counter and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grid_state <= '0;
         generation <= '0;
         stable     <= 1'b0;
         extinct    <= 1'b0;
         row_idx    <= '0;
      end else if (load_start) begin
         state      <= LOAD;
         grid_state <= '0;
         generation <= '0;
         stable     <= 1'b0;
         extinct    <= 1'b0;
         row_idx    <= '0;
      end else begin
         if (do_update) begin
            grid_state <= next_state;
            if (generation != '1) generation <= generation + GEN_WIDTH'(1);
            stable     <= stable_next;
            extinct    <= extinct_next;
         end
         case (state)
            LOAD: begin
               if (row_valid) begin
                  grid_state[row_idx*GRID_WIDTH +: GRID_WIDTH] <= row_data;
                  row_idx <= row_idx + RW'(1);
                  if (row_idx == LAST_ROW) state <= IDLE;
               end
            end
            IDLE: begin
               if (run) state <= RUN;
            end
            RUN: begin
               if (!run) state <= IDLE;
               else if (tick && (HALT_ON_STABLE != 0) && (stable_next || extinct_next))
                  state <= HALT;
            end
            HALT: ;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_life_grid_sequencer.sv
// Directed bench for life_grid_sequencer. Three instances share stimulus:
// a: defaults (period 4, halt on stable), b: halt disabled,
// c: 2-bit generation counter with period 1. A behavioural Life rule stands
// in for the combinational next-state stage.
module tb_life_grid_sequencer;

   localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
   localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;
   localparam logic [63:0] SINGLE  = 64'h0000_0000_0000_0001;
   localparam logic [63:0] PAT_A   = 64'hA5A5_0F0F_3C3C_9999;
   localparam logic [63:0] PAT_B   = 64'h0123_4567_89AB_CDEF;

   logic clk = 1'b0;
   logic rst, load_start, row_valid, run, step;
   logic [7:0] row_data;

   logic [63:0] gs_a, gs_b, gs_c, ns_a, ns_b, ns_c;
   logic [15:0] gen_a, gen_b;
   logic [1:0]  gen_c;
   logic st_a, st_b, st_c, ex_a, ex_b, ex_c, rr_a, rr_b, rr_c;
   logic [1:0] sq_a, sq_b, sq_c;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   function automatic logic [63:0] life_next(input logic [63:0] g);
      logic [63:0] r;
      int n, xx, yy;
      r = '0;
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  xx = x + dx;
                  yy = y + dy;
                  if ((dx != 0 || dy != 0) && xx >= 0 && xx < 8 && yy >= 0 && yy < 8)
                     if (g[yy*8+xx]) n++;
               end
            end
            r[y*8+x] = (n == 3) || (g[y*8+x] && n == 2);
         end
      end
      return r;
   endfunction

   always_comb ns_a = life_next(gs_a);
   always_comb ns_b = life_next(gs_b);
   always_comb ns_c = life_next(gs_c);

   life_grid_sequencer dut_a (
      .clk(clk), .rst(rst), .load_start(load_start), .row_data(row_data),
      .row_valid(row_valid), .row_ready(rr_a), .run(run), .step(step),
      .next_state(ns_a), .grid_state(gs_a), .generation(gen_a),
      .stable(st_a), .extinct(ex_a), .seq_state(sq_a));

   life_grid_sequencer #(.HALT_ON_STABLE(0)) dut_b (
      .clk(clk), .rst(rst), .load_start(load_start), .row_data(row_data),
      .row_valid(row_valid), .row_ready(rr_b), .run(run), .step(step),
      .next_state(ns_b), .grid_state(gs_b), .generation(gen_b),
      .stable(st_b), .extinct(ex_b), .seq_state(sq_b));

   life_grid_sequencer #(.GEN_WIDTH(2), .STEP_PERIOD(1), .HALT_ON_STABLE(0)) dut_c (
      .clk(clk), .rst(rst), .load_start(load_start), .row_data(row_data),
      .row_valid(row_valid), .row_ready(rr_c), .run(run), .step(step),
      .next_state(ns_c), .grid_state(gs_c), .generation(gen_c),
      .stable(st_c), .extinct(ex_c), .seq_state(sq_c));

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load_grid(input logic [63:0] pat);
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      checks++;
      if (sq_a !== 2'd1 || rr_a !== 1'b1) begin
         $display("FAIL load_enter state=%0d row_ready=%0b want 1/1", sq_a, rr_a);
         fails++;
      end
      for (int y = 0; y < 8; y++) begin
         row_data  = pat[y*8 +: 8];
         row_valid = 1'b1;
         cyc();
      end
      row_valid = 1'b0;
      checks++;
      if (sq_a !== 2'd0 || rr_a !== 1'b0 || gs_a !== pat) begin
         $display("FAIL load_done state=%0d row_ready=%0b grid=%h want 0/0/%h",
                  sq_a, rr_a, gs_a, pat);
         fails++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(2);
      checks++;
      if (sq_a !== 2'd0 || gs_a !== 64'd0 || gen_a !== 16'd0 || st_a !== 1'b0 ||
          ex_a !== 1'b0 || rr_a !== 1'b0) begin
         $display("FAIL reset_a state=%0d grid=%h gen=%0d st=%0b ex=%0b rr=%0b want all 0",
                  sq_a, gs_a, gen_a, st_a, ex_a, rr_a);
         fails++;
      end
      checks++;
      if (sq_b !== 2'd0 || gs_b !== 64'd0 || gen_b !== 16'd0 || st_b !== 1'b0 ||
          ex_b !== 1'b0 || rr_b !== 1'b0) begin
         $display("FAIL reset_b state=%0d grid=%h gen=%0d st=%0b ex=%0b rr=%0b want all 0",
                  sq_b, gs_b, gen_b, st_b, ex_b, rr_b);
         fails++;
      end
      checks++;
      if (sq_c !== 2'd0 || gs_c !== 64'd0 || gen_c !== 2'd0 || st_c !== 1'b0 ||
          ex_c !== 1'b0 || rr_c !== 1'b0) begin
         $display("FAIL reset_c state=%0d grid=%h gen=%0d st=%0b ex=%0b rr=%0b want all 0",
                  sq_c, gs_c, gen_c, st_c, ex_c, rr_c);
         fails++;
      end
      rst = 1'b0;
   endtask

   task automatic test_blinker();
      load_grid(BLINK_H);
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++;
      if (gs_a !== BLINK_V || gen_a !== 16'd1 || st_a !== 1'b0 || sq_a !== 2'd0) begin
         $display("FAIL blinker_step1 grid=%h gen=%0d st=%0b state=%0d want %h/1/0/0",
                  gs_a, gen_a, st_a, sq_a, BLINK_V);
         fails++;
      end
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++;
      if (gs_a !== BLINK_H || gen_a !== 16'd2) begin
         $display("FAIL blinker_step2 grid=%h gen=%0d want %h/2", gs_a, gen_a, BLINK_H);
         fails++;
      end
   endtask

   task automatic test_extinction();
      load_grid(SINGLE);
      step = 1'b1;
      cyc();
      step = 1'b0;
      checks++;
      if (gs_a !== 64'd0 || ex_a !== 1'b1 || st_a !== 1'b0 || gen_a !== 16'd1) begin
         $display("FAIL extinct grid=%h ex=%0b st=%0b gen=%0d want 0/1/0/1",
                  gs_a, ex_a, st_a, gen_a);
         fails++;
      end
   endtask

   task automatic test_block_halt();
      load_grid(BLOCK);
      run = 1'b1;
      cyc();
      checks++;
      if (sq_a !== 2'd2) begin
         $display("FAIL block_enter_run state=%0d want 2", sq_a);
         fails++;
      end
      cyc(3);
      checks++;
      if (gen_a !== 16'd0 || sq_a !== 2'd2) begin
         $display("FAIL block_early gen=%0d state=%0d want 0/2", gen_a, sq_a);
         fails++;
      end
      cyc();
      checks++;
      if (gen_a !== 16'd1 || st_a !== 1'b1 || sq_a !== 2'd3 || gs_a !== BLOCK) begin
         $display("FAIL block_halt gen=%0d st=%0b state=%0d grid=%h want 1/1/3/%h",
                  gen_a, st_a, sq_a, gs_a, BLOCK);
         fails++;
      end
      checks++;
      if (gen_b !== 16'd1 || st_b !== 1'b1 || sq_b !== 2'd2) begin
         $display("FAIL nohalt_stays_run gen=%0d st=%0b state=%0d want 1/1/2",
                  gen_b, st_b, sq_b);
         fails++;
      end
      step = 1'b1;
      cyc();
      step = 1'b0;
      cyc(6);
      checks++;
      if (gen_a !== 16'd1 || sq_a !== 2'd3) begin
         $display("FAIL block_frozen gen=%0d state=%0d want 1/3", gen_a, sq_a);
         fails++;
      end
      run = 1'b0;
      cyc();
      checks++;
      if (sq_a !== 2'd3 || sq_b !== 2'd0) begin
         $display("FAIL halt_ignores_run a_state=%0d b_state=%0d want 3/0", sq_a, sq_b);
         fails++;
      end
   endtask

   task automatic test_run_cadence();
      load_grid(BLINK_H);
      run = 1'b1;
      cyc();
      cyc(3);
      checks++;
      if (gen_b !== 16'd0) begin
         $display("FAIL cadence_c3 gen=%0d want 0", gen_b);
         fails++;
      end
      cyc();
      checks++;
      if (gen_b !== 16'd1 || gs_b !== BLINK_V) begin
         $display("FAIL cadence_c4 gen=%0d grid=%h want 1/%h", gen_b, gs_b, BLINK_V);
         fails++;
      end
      cyc(3);
      cyc();
      checks++;
      if (gen_b !== 16'd2) begin
         $display("FAIL cadence_c8 gen=%0d want 2", gen_b);
         fails++;
      end
      cyc(3);
      cyc();
      checks++;
      if (gen_b !== 16'd3 || gs_b !== BLINK_V || gen_a !== 16'd3) begin
         $display("FAIL cadence_c12 gen_b=%0d grid=%h gen_a=%0d want 3/%h/3",
                  gen_b, gs_b, gen_a, BLINK_V);
         fails++;
      end
      run = 1'b0;
      cyc();
      checks++;
      if (sq_b !== 2'd0) begin
         $display("FAIL cadence_stop state=%0d want 0", sq_b);
         fails++;
      end
      cyc(8);
      checks++;
      if (gen_b !== 16'd3 || gs_b !== BLINK_V) begin
         $display("FAIL cadence_idle gen=%0d grid=%h want 3/%h", gen_b, gs_b, BLINK_V);
         fails++;
      end
   endtask

   task automatic test_load_handshake();
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int y = 0; y < 2; y++) begin
         row_data  = PAT_A[y*8 +: 8];
         row_valid = 1'b1;
         cyc();
      end
      row_valid = 1'b0;
      row_data  = 8'hFF;
      step      = 1'b1;
      cyc(2);
      step      = 1'b0;
      checks++;
      if (rr_a !== 1'b1 || sq_a !== 2'd1 || gs_a !== (PAT_A & 64'hFFFF) || gen_a !== 16'd0) begin
         $display("FAIL load_gap rr=%0b state=%0d grid=%h gen=%0d want 1/1/%h/0",
                  rr_a, sq_a, gs_a, gen_a, PAT_A & 64'hFFFF);
         fails++;
      end
      for (int y = 2; y < 8; y++) begin
         row_data  = PAT_A[y*8 +: 8];
         row_valid = 1'b1;
         cyc();
      end
      row_valid = 1'b0;
      checks++;
      if (gs_a !== PAT_A || sq_a !== 2'd0 || rr_a !== 1'b0) begin
         $display("FAIL load_gap_done grid=%h state=%0d rr=%0b want %h/0/0",
                  gs_a, sq_a, rr_a, PAT_A);
         fails++;
      end
   endtask

   task automatic test_load_restart();
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int y = 0; y < 3; y++) begin
         row_data  = 8'hFF;
         row_valid = 1'b1;
         cyc();
      end
      row_valid  = 1'b0;
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      checks++;
      if (gs_a !== 64'd0 || sq_a !== 2'd1) begin
         $display("FAIL load_restart_clear grid=%h state=%0d want 0/1", gs_a, sq_a);
         fails++;
      end
      for (int y = 0; y < 8; y++) begin
         row_data  = PAT_B[y*8 +: 8];
         row_valid = 1'b1;
         cyc();
      end
      row_valid = 1'b0;
      checks++;
      if (gs_a !== PAT_B || sq_a !== 2'd0) begin
         $display("FAIL load_restart_rows grid=%h state=%0d want %h/0", gs_a, sq_a, PAT_B);
         fails++;
      end
   endtask

   task automatic test_reset_in_load();
      load_start = 1'b1;
      cyc();
      load_start = 1'b0;
      for (int y = 0; y < 2; y++) begin
         row_data  = 8'h5A;
         row_valid = 1'b1;
         cyc();
      end
      rst        = 1'b1;
      load_start = 1'b1;
      cyc();
      rst        = 1'b0;
      load_start = 1'b0;
      row_valid  = 1'b0;
      checks++;
      if (sq_a !== 2'd0 || gs_a !== 64'd0 || rr_a !== 1'b0 || gen_a !== 16'd0 ||
          st_a !== 1'b0 || ex_a !== 1'b0) begin
         $display("FAIL reset_in_load state=%0d grid=%h rr=%0b gen=%0d st=%0b ex=%0b want all 0",
                  sq_a, gs_a, rr_a, gen_a, st_a, ex_a);
         fails++;
      end
   endtask

   task automatic test_saturation();
      load_grid(BLINK_H);
      run = 1'b1;
      cyc();
      cyc(3);
      checks++;
      if (gen_c !== 2'b11 || gs_c !== BLINK_V) begin
         $display("FAIL sat_u3 gen=%0d grid=%h want 3/%h", gen_c, gs_c, BLINK_V);
         fails++;
      end
      cyc();
      checks++;
      if (gen_c !== 2'b11 || gs_c !== BLINK_H) begin
         $display("FAIL sat_u4 gen=%0d grid=%h want 3/%h", gen_c, gs_c, BLINK_H);
         fails++;
      end
      cyc();
      checks++;
      if (gen_c !== 2'b11 || gs_c !== BLINK_V || sq_c !== 2'd2) begin
         $display("FAIL sat_u5 gen=%0d grid=%h state=%0d want 3/%h/2",
                  gen_c, gs_c, sq_c, BLINK_V);
         fails++;
      end
      run = 1'b0;
      cyc();
   endtask

   initial begin
      rst        = 1'b1;
      load_start = 1'b0;
      row_valid  = 1'b0;
      row_data   = 8'h00;
      run        = 1'b0;
      step       = 1'b0;
      test_reset();
      test_blinker();
      test_extinction();
      test_block_halt();
      test_run_cadence();
      test_load_handshake();
      test_load_restart();
      test_reset_in_load();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
